// File: rtl/picomips_pkg.sv
// picomips_pkg: shared constants and types for the picoMIPS PC/ready front end.
//   PSIZE_DEFAULT : default program counter / program memory address width
//   pc_t          : program counter type at the default width
//   db_state_t    : ready debounce FSM states
package picomips_pkg;
   localparam int PSIZE_DEFAULT = 6;
   typedef logic [PSIZE_DEFAULT-1:0] pc_t;
   typedef enum logic {DB_STABLE, DB_COUNTING} db_state_t;
endpackage

// File: rtl/ready_debounce.sv
// ready_debounce: 2-flop synchroniser plus optional debounce FSM for the ready switch.
//   Build option: PICO_DEBOUNCE_EN (defined = debounce FSM, undefined = synchroniser only)
//   clk        in  : system clock
//   nreset     in  : asynchronous active-low reset
//   ready_raw  in  : asynchronous, bouncy switch input
//   readyin    out : synchronised (and, if enabled, debounced) ready level
//   ready_rise out : one-cycle pulse in the first cycle readyin is 1
module ready_debounce import picomips_pkg::*; #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic nreset,
   input  logic ready_raw,
   output logic readyin,
   output logic ready_rise
);
   logic s1_q, s_q, rise_q;
   if (DEB_CYCLES < 2) begin : g_bad_deb
      $error("DEB_CYCLES must be at least 2");
   end
`ifdef PICO_DEBOUNCE_EN
   localparam int CW = $clog2(DEB_CYCLES);
   db_state_t     state_q;
   logic [CW-1:0] cnt_q;
   logic          rdy_q;
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         s1_q    <= 1'b0;
         s_q     <= 1'b0;
         rdy_q   <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
         state_q <= DB_STABLE;
      end else begin
         s1_q   <= ready_raw;
         s_q    <= s1_q;
         rise_q <= 1'b0;
         case (state_q)
            DB_STABLE: if (s_q != rdy_q) begin
               state_q <= DB_COUNTING;
               cnt_q   <= CW'(1);
            end
            DB_COUNTING: if (s_q == rdy_q) begin
               state_q <= DB_STABLE;
               cnt_q   <= '0;
            end else if (cnt_q == CW'(DEB_CYCLES-1)) begin
               // Level held long enough: accept it, pulse only on a 0->1 change
               rdy_q   <= s_q;
               rise_q  <= s_q;
               cnt_q   <= '0;
               state_q <= DB_STABLE;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
            default: state_q <= DB_STABLE;
         endcase
      end
   end
   assign readyin = rdy_q;
`else
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         s1_q   <= 1'b0;
         s_q    <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         s1_q   <= ready_raw;
         s_q    <= s1_q;
         rise_q <= s1_q & ~s_q;
      end
   end
   assign readyin = s_q;
`endif
   assign ready_rise = rise_q;
endmodule

// File: rtl/pc_ready_unit.sv
// pc_ready_unit: picoMIPS program counter plus conditioned ready input for the decoder.
//   Build option: PICO_DEBOUNCE_EN enables the ready debounce FSM in ready_debounce.
//   clk         in  : system clock
//   nreset      in  : asynchronous active-low reset
//   en          in  : run enable, gates PC and wrap flag only
//   PCincr      in  : advance PC by 1
//   PCrelbranch in  : add signed Branchaddr to PC (wins over PCincr)
//   Branchaddr  in  : signed relative branch offset
//   ready_raw   in  : raw ready switch
//   PCout       out : program counter
//   readyin     out : clean ready level
//   ready_rise  out : one-cycle pulse when readyin goes 0->1
//   wrapped     out : sticky flag, PCincr took PC from all-ones to zero
module pc_ready_unit import picomips_pkg::*; #(
   parameter int PSIZE      = PSIZE_DEFAULT,
   parameter int DEB_CYCLES = 16
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             en,
   input  logic             PCincr,
   input  logic             PCrelbranch,
   input  logic [PSIZE-1:0] Branchaddr,
   input  logic             ready_raw,
   output logic [PSIZE-1:0] PCout,
   output logic             readyin,
   output logic             ready_rise,
   output logic             wrapped
);
   logic [PSIZE-1:0] pc_q, pc_d;
   logic             wrap_q, wrap_d;
   // Same-width add gives the sign-extended offset modulo 2^PSIZE
   always_comb begin
      pc_d   = !en ? pc_q : PCrelbranch ? pc_q + Branchaddr : PCincr ? pc_q + PSIZE'(1) : pc_q;
      wrap_d = wrap_q | (en & ~PCrelbranch & PCincr & (&pc_q));
   end
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         pc_q   <= '0;
         wrap_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         wrap_q <= wrap_d;
      end
   end
   assign PCout   = pc_q;
   assign wrapped = wrap_q;
   ready_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_ready (
      .clk       (clk),
      .nreset    (nreset),
      .ready_raw (ready_raw),
      .readyin   (readyin),
      .ready_rise(ready_rise)
   );
endmodule

// File: tb/tb_pc_ready_unit.sv
// tb_pc_ready_unit: self-checking bench for pc_ready_unit (PC vectors + ready sequences).
module tb_pc_ready_unit;
   import picomips_pkg::*;
`ifdef PICO_DEBOUNCE_EN
   localparam int LAT = 18;
   localparam bit DEB = 1'b1;
`else
   localparam int LAT = 2;
   localparam bit DEB = 1'b0;
`endif
   logic clk = 1'b0, nreset = 1'b0, en = 1'b0, incr = 1'b0, rel = 1'b0, ready_raw = 1'b0;
   pc_t  baddr = '0, pc;
   logic readyin, ready_rise, wrapped;
   int   n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   pc_ready_unit #(.PSIZE(PSIZE_DEFAULT), .DEB_CYCLES(16)) dut (
      .clk        (clk),
      .nreset     (nreset),
      .en         (en),
      .PCincr     (incr),
      .PCrelbranch(rel),
      .Branchaddr (baddr),
      .ready_raw  (ready_raw),
      .PCout      (pc),
      .readyin    (readyin),
      .ready_rise (ready_rise),
      .wrapped    (wrapped)
   );
   typedef struct {logic en; logic incr; logic rel; pc_t ba; pc_t pc; logic wr;} vec_t;
   typedef struct {pc_t pc; logic wr;} exp_t;
   vec_t tbl[20];
   exp_t sb[$];
   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   // Count edges until readyin reaches lvl (bounded), also counting ready_rise pulses seen
   task automatic wait_lvl(input logic lvl, output int n, output int rises);
      n = 0;
      rises = 0;
      while (readyin !== lvl && n < 60) begin
         tick();
         n++;
         rises += int'(ready_rise);
      end
   endtask
   initial begin
      int n, r;
      logic prev;
      exp_t e;
      tbl = '{
         '{1'b1, 1'b1, 1'b0, 6'd0,  6'd1,  1'b0},
         '{1'b1, 1'b1, 1'b0, 6'd0,  6'd2,  1'b0},
         '{1'b1, 1'b1, 1'b0, 6'd0,  6'd3,  1'b0},
         '{1'b1, 1'b1, 1'b0, 6'd0,  6'd4,  1'b0},
         '{1'b1, 1'b1, 1'b0, 6'd0,  6'd5,  1'b0},
         '{1'b1, 1'b0, 1'b1, 6'd58, 6'd63, 1'b0},
         '{1'b1, 1'b0, 1'b1, 6'd1,  6'd0,  1'b0},
         '{1'b1, 1'b0, 1'b1, 6'd31, 6'd31, 1'b0},
         '{1'b1, 1'b0, 1'b1, 6'd31, 6'd62, 1'b0},
         '{1'b1, 1'b1, 1'b0, 6'd0,  6'd63, 1'b0},
         '{1'b1, 1'b1, 1'b0, 6'd0,  6'd0,  1'b1},
         '{1'b1, 1'b0, 1'b1, 6'd63, 6'd63, 1'b1},
         '{1'b0, 1'b1, 1'b0, 6'd0,  6'd63, 1'b1},
         '{1'b1, 1'b1, 1'b0, 6'd0,  6'd0,  1'b1},
         '{1'b1, 1'b0, 1'b1, 6'd10, 6'd10, 1'b1},
         '{1'b1, 1'b1, 1'b1, 6'd61, 6'd7,  1'b1},
         '{1'b1, 1'b0, 1'b1, 6'd0,  6'd7,  1'b1},
         '{1'b0, 1'b1, 1'b0, 6'd0,  6'd7,  1'b1},
         '{1'b0, 1'b0, 1'b1, 6'd5,  6'd7,  1'b1},
         '{1'b1, 1'b1, 1'b0, 6'd0,  6'd8,  1'b1}
      };
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", int'(pc), 0);
      chk("rst_wrapped", int'(wrapped), 0);
      chk("rst_readyin", int'(readyin), 0);
      chk("rst_rise", int'(ready_rise), 0);
      nreset = 1'b1;
      foreach (tbl[i]) begin
         en = tbl[i].en;
         incr = tbl[i].incr;
         rel = tbl[i].rel;
         baddr = tbl[i].ba;
         sb.push_back('{tbl[i].pc, tbl[i].wr});
         tick();
         e = sb.pop_front();
         chk($sformatf("pc_vec%0d", i), int'(pc), int'(e.pc));
         chk($sformatf("wrap_vec%0d", i), int'(wrapped), int'(e.wr));
      end
      en = 1'b0;
      incr = 1'b0;
      rel = 1'b0;
      baddr = '0;
      ready_raw = 1'b1;
      wait_lvl(1'b1, n, r);
      chk("rise_latency", n, LAT);
      chk("rise_pulses", r, 1);
      tick();
      chk("rise_one_cycle", int'(ready_rise), 0);
      chk("rise_level_held", int'(readyin), 1);
      ready_raw = 1'b0;
      wait_lvl(1'b0, n, r);
      chk("fall_latency", n, LAT);
      chk("fall_no_pulse", r, 0);
      prev = 1'b0;
      for (int i = 0; i < 13; i++) begin
         ready_raw = (i < 10);
         tick();
         chk($sformatf("bounce%0d", i), int'(readyin), DEB ? 0 : int'(prev));
         prev = ready_raw;
      end
      ready_raw = 1'b1;
      wait_lvl(1'b1, n, r);
      chk("bounce_final_latency", n, LAT);
      ready_raw = 1'b0;
      wait_lvl(1'b0, n, r);
      chk("bounce_fall_latency", n, LAT);
      ready_raw = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (i == 1) ready_raw = 1'b0;
         chk($sformatf("glitch%0d", i), int'(readyin), int'(!DEB && i == 2));
         chk($sformatf("glitch_rise%0d", i), int'(ready_rise), int'(!DEB && i == 2));
      end
      ready_raw = 1'b1;
      en = 1'b1;
      incr = 1'b1;
      repeat (12) tick();
      chk("pc_before_reset", int'(pc), 20);
      chk("rdy_before_reset", int'(readyin), int'(12 >= LAT));
      nreset = 1'b0;
      #1;
      chk("mid_rst_pc", int'(pc), 0);
      chk("mid_rst_readyin", int'(readyin), 0);
      chk("mid_rst_rise", int'(ready_rise), 0);
      chk("mid_rst_wrapped", int'(wrapped), 0);
      en = 1'b0;
      incr = 1'b0;
      #1;
      nreset = 1'b1;
      wait_lvl(1'b1, n, r);
      chk("post_rst_latency", n, LAT);
      chk("post_rst_rise", r, 1);
      chk("post_rst_pc", int'(pc), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
